uart_input_buffer: RTL and testbench
====================================

# uart_input_buffer

Receive-side UART front end for the core's input path. Deserialises 8N1 bytes from the serial line, packs four consecutive bytes big-endian into a 32-bit word, and queues words in a small FIFO. The write-back/PC-generate stage consumes words through the `input_ready` / `input_data` pair and pops them with `UART_read_enable` when executing a UART-to-register instruction.

## Interface

- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `FIFO_DEPTH_LOG`, default 2: log2 of the word FIFO depth (default 4 words).

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input, idle high; asynchronous to `clk`.
- `UART_read_enable`  in  1  pops the head word at the clock edge; ignored while `input_ready` = 0.
- `error_clear`  in  1  synchronous clear of `overrun` and `frame_error`.
- `input_ready`  out  1  FIFO not empty.
- `input_data`  out  32  FIFO head word (show-ahead); 0 when empty.
- `overrun`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `frame_error`  out  1  sticky: a byte had stop bit = 0.

## Operation

- `rxd` passes through a 2-flop synchroniser, preset to 1 by reset; all RX logic uses the synchronised bit.
- RX FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a cycle counter are wide enough for `CLK_PER_BIT`.
  - IDLE: on synchronised `rxd` = 0, load the cycle counter and enter START.
  - START: after `CLK_PER_BIT/2` cycles (integer division), sample. If 0, enter DATA with the bit counter at 0. If 1, treat it as a glitch and return to IDLE.
  - DATA: sample every `CLK_PER_BIT` cycles, LSB first, into the shift register. After bit 7, enter STOP.
  - STOP: sample after `CLK_PER_BIT` cycles, then return to IDLE. A 1 delivers the byte. A 0 sets `frame_error` and discards the byte; the byte count is not advanced.
- Word assembly: a byte counter (0..3) and a 24-bit partial register. Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - Delivery of byte 3 forms the full word and pushes it; the byte counter wraps to 0.
- FIFO: circular buffer of 2^`FIFO_DEPTH_LOG` words. Read/write pointers carry one extra bit for full/empty detection and wrap modulo 2·depth.
  - Push when full and no pop in the same cycle: word dropped, `overrun` set, FIFO contents unchanged.
  - Push and pop in the same cycle: both take effect, including when full. No overrun; occupancy unchanged.
  - Pop when empty: no effect.
- `input_data` is the registered head entry, forced to 0 when empty.
- Flags: `overrun` and `frame_error` are set by their events and cleared by `error_clear` or reset. A set event in the same cycle as `error_clear` wins: the flag stays 1.
- Reset mid-frame or mid-word: discards the partial byte, the partial word and all FIFO contents.

## Timing

- Reset values: `input_ready` 0, `input_data` 0, `overrun` 0, `frame_error` 0. FSM in IDLE, all counters 0, synchroniser flops 1.
- Sampling: the start edge is seen 2 cycles after `rxd` falls (synchroniser). With N = `CLK_PER_BIT`, sample points fall at N/2, N/2+N·(k+1) for data bit k, and N/2+9N cycles after detection.
- Push latency: `input_ready` rises (if it was 0) on the edge after the stop-bit sample of byte 3. `input_data` is valid in the same cycle.
- Pop: `UART_read_enable` high while `input_ready` = 1 advances the head at that edge. The next word, or 0/`input_ready` = 0 if that was the last word, is visible the following cycle.
- One pop per cycle at most. Back-to-back pops drain one word per cycle.
- Throughput: a byte takes 10N cycles; no gap between frames is required. The FSM is back in IDLE by the middle of the stop bit and catches a start bit that immediately follows.

## Test plan

- Reset: drive `reset` = 0 mid-simulation. Required: all outputs 0. `rxd` held 1 for 1000 cycles -> `input_ready` stays 0.
- Single word (`CLK_PER_BIT` = 16): send 0x12, 0x34, 0x56, 0x78. Required: `input_ready` = 1 and `input_data` = 0x12345678 one cycle after the last stop sample; one-cycle `UART_read_enable` -> `input_ready` 0, `input_data` 0.
- Glitch and framing: a 4-cycle low pulse on `rxd` -> no byte. Then send 0xAA, a 0xBB frame with stop bit 0, then 0xCC, 0xDD, 0xEE. Required: `frame_error` = 1 and word = 0xAACCDDEE. `error_clear` -> `frame_error` 0.
- Full/overrun: send 5 words W1..W5 with no pops. Required: `overrun` = 1 after W5, head = W1. Four pops return W1..W4 in order, then `input_ready` = 0.
- Simultaneous push/pop: FIFO full with 4 words; assert `UART_read_enable` in the cycle W5 is pushed. Required: `overrun` stays 0; subsequent pops return W2, W3, W4, W5.
- Reset mid-word: send 0x01, 0x02, pulse `reset` low in the middle of the third frame, then send 0x11, 0x22, 0x33, 0x44. Required: the only word is 0x11223344.

Source files
------------

// File: rtl/uart_input_buffer_if.sv
// rtl/uart_input_buffer_if.sv - word read port between the UART input buffer and its consumer
interface uart_input_buffer_if;
  logic        UART_read_enable;
  logic        input_ready;
  logic [31:0] input_data;

  modport master (
    output UART_read_enable,
    input  input_ready,
    input  input_data
  );

  modport slave (
    input  UART_read_enable,
    output input_ready,
    output input_data
  );
endinterface

// File: rtl/uart_input_buffer.sv
// rtl/uart_input_buffer.sv - 8N1 receiver packing big-endian 32-bit words into a show-ahead FIFO
module uart_input_buffer #(
  parameter int CLK_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  input  logic                error_clear,
  output logic                overrun,
  output logic                frame_error,
  uart_input_buffer_if.slave  host
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int PW    = FIFO_DEPTH_LOG + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic            rxd_meta;
  logic            rxd_sync;
  logic [CW-1:0]   cyc;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            byte_valid;
  logic [1:0]      byte_cnt;
  logic [23:0]     partial;
  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            do_write;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign push     = byte_valid && (byte_cnt == 2'd3);
  assign pop      = host.UART_read_enable && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign do_write = push && (!full || pop);

  assign host.input_ready = !empty;
  assign host.input_data  = empty ? 32'd0 : mem[rd_ptr[PW-2:0]];

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Receive FSM: mid-bit sampling, LSB-first shift, one-cycle byte_valid on a good stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cyc         <= '0;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (error_clear) frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_sync) begin
            cyc   <= HALF_M1;
            state <= START;
          end
        end
        START: begin
          if (cyc != '0) begin
            cyc <= cyc - 1'b1;
          end else if (!rxd_sync) begin
            cyc     <= FULL_M1;
            bit_cnt <= 3'd0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cyc != '0) begin
            cyc <= cyc - 1'b1;
          end else begin
            shift <= {rxd_sync, shift[7:1]};
            cyc   <= FULL_M1;
            if (bit_cnt == 3'd7) state <= STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (cyc != '0) begin
            cyc <= cyc - 1'b1;
          end else begin
            state <= IDLE;
            if (rxd_sync) byte_valid  <= 1'b1;
            else          frame_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word assembly: first byte lands in the most significant lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      partial  <= 24'd0;
    end else if (byte_valid) begin
      case (byte_cnt)
        2'd0:    partial[23:16] <= shift;
        2'd1:    partial[15:8]  <= shift;
        2'd2:    partial[7:0]   <= shift;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // FIFO storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[PW-2:0]] <= {partial, shift};
  end

  // FIFO pointers and the sticky overrun flag; a set event beats error_clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overrun <= 1'b1;
      else if (error_clear)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_input_buffer.sv
// tb/tb_uart_input_buffer.sv - scoreboard bench for uart_input_buffer
module tb_uart_input_buffer;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rxd = 1'b1;
  logic error_clear = 1'b0;
  logic overrun;
  logic frame_error;

  uart_input_buffer_if ifc();

  uart_input_buffer #(.CLK_PER_BIT(N), .FIFO_DEPTH_LOG(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .error_clear (error_clear),
    .overrun     (overrun),
    .frame_error (frame_error),
    .host        (ifc)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rise_at;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame edge by edge; optionally pops (checking the head) in the cycle before edge pop_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at);
    logic [9:0] f;
    logic       was;
    f       = {stop, b, 1'b0};
    was     = ifc.input_ready;
    rise_at = -1;
    for (int e = 0; e < 10 * N; e++) begin
      rxd = f[e / N];
      if (pop_at != 0 && e + 1 == pop_at) begin
        if (exp_q.size() > 0) check_eq("simul_head", ifc.input_data, exp_q.pop_front());
        ifc.UART_read_enable = 1'b1;
      end
      @(posedge clk);
      #1;
      ifc.UART_read_enable = 1'b0;
      if (!was && ifc.input_ready && rise_at < 0) rise_at = e + 1;
    end
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int pop_at);
    send_frame(w[31:24], 1'b1, 0);
    send_frame(w[23:16], 1'b1, 0);
    send_frame(w[15:8],  1'b1, 0);
    send_frame(w[7:0],   1'b1, pop_at);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = 32'hDEAD_BEEF;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_eq({tag, "_rdy"}, {31'd0, ifc.input_ready}, 32'd1);
    check_eq(tag, ifc.input_data, e);
    ifc.UART_read_enable = 1'b1;
    @(posedge clk);
    #1;
    ifc.UART_read_enable = 1'b0;
  endtask

  initial begin
    ifc.UART_read_enable = 1'b0;

    // Reset state and idle line.
    idle(3);
    check_eq("rst_rdy",  {31'd0, ifc.input_ready}, 32'd0);
    check_eq("rst_data", ifc.input_data, 32'd0);
    check_eq("rst_ovr",  {31'd0, overrun}, 32'd0);
    check_eq("rst_fe",   {31'd0, frame_error}, 32'd0);
    reset = 1'b1;
    idle(1000);
    check_eq("idle_rdy", {31'd0, ifc.input_ready}, 32'd0);

    // Single word with push latency.
    exp_q.push_back(32'h1234_5678);
    send_word(32'h1234_5678, 0);
    check_eq("latency", rise_at, 9 * N + N / 2 + 4);
    pop_check("single");
    check_eq("single_empty_rdy",  {31'd0, ifc.input_ready}, 32'd0);
    check_eq("single_empty_data", ifc.input_data, 32'd0);

    // Glitch rejection and framing error.
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(2 * N);
    check_eq("glitch_rdy", {31'd0, ifc.input_ready}, 32'd0);
    check_eq("glitch_fe",  {31'd0, frame_error}, 32'd0);
    send_frame(8'hAA, 1'b1, 0);
    send_frame(8'hBB, 1'b0, 0);
    idle(2 * N);
    send_frame(8'hCC, 1'b1, 0);
    send_frame(8'hDD, 1'b1, 0);
    send_frame(8'hEE, 1'b1, 0);
    exp_q.push_back(32'hAACC_DDEE);
    check_eq("fe_set", {31'd0, frame_error}, 32'd1);
    pop_check("frame_word");
    error_clear = 1'b1;
    idle(1);
    error_clear = 1'b0;
    check_eq("fe_clear", {31'd0, frame_error}, 32'd0);

    // Full FIFO and overrun: W5 is dropped.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(32'hA0B0_0000 + i);
      send_word(32'hA0B0_0000 + i, 0);
      if (i == 4) check_eq("ovr_before", {31'd0, overrun}, 32'd0);
    end
    check_eq("ovr_set", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");
    check_eq("ovr_drained", {31'd0, ifc.input_ready}, 32'd0);
    error_clear = 1'b1;
    idle(1);
    error_clear = 1'b0;
    check_eq("ovr_clear", {31'd0, overrun}, 32'd0);

    // Simultaneous push and pop on a full FIFO.
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(32'h5E00_0000 + i);
      send_word(32'h5E00_0000 + i, 0);
    end
    send_word(32'h5E00_0005, 9 * N + N / 2 + 4);
    exp_q.push_back(32'h5E00_0005);
    check_eq("simul_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) pop_check("simul_pop");
    check_eq("simul_drained", {31'd0, ifc.input_ready}, 32'd0);

    // Reset mid-word discards FIFO contents, partial word and partial byte.
    send_word(32'hCAFE_F00D, 0);
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    rxd = 1'b0;
    idle(4 * N);
    rxd = 1'b1;
    idle(N / 2);
    reset = 1'b0;
    idle(2);
    check_eq("midrst_rdy",  {31'd0, ifc.input_ready}, 32'd0);
    check_eq("midrst_data", ifc.input_data, 32'd0);
    reset = 1'b1;
    idle(2 * N);
    exp_q.push_back(32'h1122_3344);
    send_word(32'h1122_3344, 0);
    pop_check("midrst_word");
    check_eq("midrst_empty", {31'd0, ifc.input_ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
